regfile_mp: RTL and testbench

Parametrised multi-port integer register file, the next generation of the datapath register file. It provides NREAD combinational read ports and two write ports with same-cycle write-to-read bypass and a configurable hardwired-zero register. A built-in clear sequencer zeroes the array row-by-row after reset or on request. It sits between decode (read addresses) and writeback (ALU and load return paths).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_clear_seq.sv | 64 ++++++
 rtl/regfile_mp.sv | 72 +++++++
 tb/tb_regfile_mp.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package regfile_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int DEFAULT_ZERO_REG = 31;

  // Address width for n entries, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bundle of the register file: read ports, two write ports, clear and ready.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int AW = clog2(DEPTH);

  logic [NREAD*AW-1:0]    RA;
  logic [NREAD*WIDTH-1:0] BusA;
  logic [AW-1:0]          RW0;
  logic [WIDTH-1:0]       BusW0;
  logic                   RegWr0;
  logic [AW-1:0]          RW1;
  logic [WIDTH-1:0]       BusW1;
  logic                   RegWr1;
  logic                   Clear;
  logic                   Ready;

  modport master (
    output RA, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1, Clear,
    input  BusA, Ready
  );

  modport slave (
    input  RA, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1, Clear,
    output BusA, Ready
  );
endinterface

// File: rtl/regfile_clear_seq.sv
// Init/clear sequencer: sweeps every row to zero after reset or a Clear request, then raises ready.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  output logic          ready_o,
  output logic          sweep_we_o,
  output logic [AW-1:0] sweep_addr_o
);

  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] row_q;
  logic          ready_q;
  logic          sweep_q;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      row_q   <= '0;
      ready_q <= 1'b0;
      sweep_q <= 1'b1;
    end else begin
      case (state_q)
        INIT, CLEAR: begin
          if (row_q == LAST_ROW) begin
            state_q <= RUN;
            row_q   <= '0;
            ready_q <= 1'b1;
            sweep_q <= 1'b0;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        RUN: begin
          if (clear_i) begin
            state_q <= CLEAR;
            row_q   <= '0;
            ready_q <= 1'b0;
            sweep_q <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
          row_q   <= '0;
          ready_q <= 1'b0;
          sweep_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign sweep_we_o   = sweep_q;
  assign sweep_addr_o = row_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads with write bypass, two write ports, hardwired zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
  input  logic         Clk,
  input  logic         ResetN,
  regfile_mp_if.slave  bus
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             ready;
  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;
  logic             wr0_ok;
  logic             wr1_ok;

  regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk          (Clk),
    .rst_n        (ResetN),
    .clear_i      (bus.Clear),
    .ready_o      (ready),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr)
  );

  // Addresses past the end and the hardwired-zero row are never stored or read.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && (32'(a) != ZERO_REG);
  endfunction

  assign wr0_ok = ready && bus.RegWr0 && addr_ok(bus.RW0);
  assign wr1_ok = ready && bus.RegWr1 && addr_ok(bus.RW1);

  // NOTE: the array has no reset; the sweep is the only thing that initialises it.
  always_ff @(posedge Clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else begin
      if (wr0_ok) mem[bus.RW0] <= bus.BusW0;
      if (wr1_ok) mem[bus.RW1] <= bus.BusW1;
    end
  end

  assign bus.Ready = ready;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = bus.RA[k*AW +: AW];

    // Port 1 is checked first so a load return overrides a same-address ALU result.
    always_comb begin
      rd = '0;
      if (ready && addr_ok(ra)) begin
        if (wr1_ok && (bus.RW1 == ra))      rd = bus.BusW1;
        else if (wr0_ok && (bus.RW0 == ra)) rd = bus.BusW0;
        else                                rd = mem[ra];
      end
    end

    assign bus.BusA[k*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: sweep timing, bypass, port priority, zero/out-of-range, clear and reset.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 Clk = ~Clk;

  regfile_mp_if #(.WIDTH(64), .DEPTH(32), .NREAD(2)) bus32 ();
  regfile_mp_if #(.WIDTH(64), .DEPTH(24), .NREAD(2)) bus24 ();

  regfile_mp #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_REG(31)) dut32 (
    .Clk(Clk), .ResetN(ResetN), .bus(bus32)
  );
  regfile_mp #(.WIDTH(64), .DEPTH(24), .NREAD(2), .ZERO_REG(31)) dut24 (
    .Clk(Clk), .ResetN(ResetN), .bus(bus24)
  );

  typedef struct {
    string       name;
    logic [4:0]  ra0, ra1;
    logic [4:0]  rw0;
    logic [63:0] w0;
    logic        we0;
    logic [4:0]  rw1;
    logic [63:0] w1;
    logic        we1;
    logic [63:0] exp0, exp1;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive32(input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [4:0] rw0, input logic [63:0] w0, input logic we0,
                         input logic [4:0] rw1, input logic [63:0] w1, input logic we1);
    bus32.RA     = {ra1, ra0};
    bus32.RW0    = rw0;
    bus32.BusW0  = w0;
    bus32.RegWr0 = we0;
    bus32.RW1    = rw1;
    bus32.BusW1  = w1;
    bus32.RegWr1 = we1;
  endtask

  task automatic drive24(input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [4:0] rw0, input logic [63:0] w0, input logic we0,
                         input logic [4:0] rw1, input logic [63:0] w1, input logic we1);
    bus24.RA     = {ra1, ra0};
    bus24.RW0    = rw0;
    bus24.BusW0  = w0;
    bus24.RegWr0 = we0;
    bus24.RW1    = rw1;
    bus24.BusW1  = w1;
    bus24.RegWr1 = we1;
  endtask

  // Counts edges until dut32 is ready (bounded); pulses Clear before edge clear_at to show it is ignored.
  task automatic count_ready(input int clear_at, output int n32, output int n24);
    n32 = 0;
    n24 = -1;
    while (!bus32.Ready && n32 < 200) begin
      bus32.Clear = (n32 == clear_at);
      step();
      n32++;
      if (bus24.Ready && n24 < 0) n24 = n32;
    end
    bus32.Clear = 1'b0;
  endtask

  initial begin
    int n32, n24;

    vecs[0] = '{"bypass_p0",     5'd5,  5'd6,  5'd5,  64'h1234, 1'b1, 5'd0, 64'h0,    1'b0, 64'h1234, 64'h0};
    vecs[1] = '{"stored_p0",     5'd5,  5'd0,  5'd0,  64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 64'h1234, 64'h0};
    vecs[2] = '{"dual_same_byp", 5'd7,  5'd5,  5'd7,  64'hAAAA, 1'b1, 5'd7, 64'hBBBB, 1'b1, 64'hBBBB, 64'h1234};
    vecs[3] = '{"dual_same_st",  5'd7,  5'd7,  5'd0,  64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 64'hBBBB, 64'hBBBB};
    vecs[4] = '{"zero_reg_byp",  5'd31, 5'd1,  5'd31, 64'hFFFF, 1'b1, 5'd1, 64'h11,   1'b1, 64'h0,    64'h11};
    vecs[5] = '{"zero_reg_st",   5'd31, 5'd30, 5'd0,  64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 64'h0,    64'h0};
    vecs[6] = '{"we_low",        5'd9,  5'd1,  5'd9,  64'h99,   1'b0, 5'd9, 64'h98,   1'b0, 64'h0,    64'h11};
    vecs[7] = '{"dual_diff_byp", 5'd2,  5'd3,  5'd2,  64'h22,   1'b1, 5'd3, 64'h33,   1'b1, 64'h22,   64'h33};
    vecs[8] = '{"dual_diff_st",  5'd2,  5'd3,  5'd0,  64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 64'h22,   64'h33};
    vecs[9] = '{"p1_only",       5'd4,  5'd9,  5'd0,  64'h0,    1'b0, 5'd4, 64'h44,   1'b1, 64'h44,   64'h0};

    drive32(5'd3, 5'd4, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
    drive24(5'd0, 5'd0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
    bus32.Clear = 1'b0;
    bus24.Clear = 1'b0;

    #3;
    check("reset_ready32", 64'(bus32.Ready), 64'h0);
    check("reset_busa0", bus32.BusA[63:0], 64'h0);
    check("reset_busa1", bus32.BusA[127:64], 64'h0);
    check("reset_ready24", 64'(bus24.Ready), 64'h0);

    @(negedge Clk) ResetN = 1'b1;
    count_ready(5, n32, n24);
    check("init_sweep_len32", 64'(n32), 64'd32);
    check("init_sweep_len24", 64'(n24), 64'd24);

    // Preload reg 3 front-door, then reset mid-RUN: the sweep must wipe it.
    drive32(5'd3, 5'd0, 5'd3, 64'hDEAD, 1'b1, 5'd0, 64'h0, 1'b0);
    step();
    drive32(5'd3, 5'd0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
    #1;
    check("preload_dead", bus32.BusA[63:0], 64'hDEAD);
    ResetN = 1'b0;
    #1;
    check("async_reset_ready", 64'(bus32.Ready), 64'h0);
    check("async_reset_busa", bus32.BusA[63:0], 64'h0);
    @(negedge Clk) ResetN = 1'b1;
    count_ready(-1, n32, n24);
    check("reinit_sweep_len", 64'(n32), 64'd32);
    for (int i = 0; i < 32; i++) begin
      drive32(5'(i), 5'(31 - i), 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
      #1;
      check($sformatf("swept_p0_r%0d", i), bus32.BusA[63:0], 64'h0);
      check($sformatf("swept_p1_r%0d", 31 - i), bus32.BusA[127:64], 64'h0);
    end

    // DEPTH=24: address 28 is out of range, 23 is the last real row.
    drive24(5'd28, 5'd23, 5'd28, 64'hFFFF, 1'b1, 5'd23, 64'h2323, 1'b1);
    #1;
    check("d24_oor_byp", bus24.BusA[63:0], 64'h0);
    check("d24_last_byp", bus24.BusA[127:64], 64'h2323);
    step();
    drive24(5'd28, 5'd31, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
    #1;
    check("d24_oor_st", bus24.BusA[63:0], 64'h0);
    check("d24_r31", bus24.BusA[127:64], 64'h0);
    for (int i = 0; i < 24; i++) begin
      drive24(5'(i), 5'd0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
      #1;
      check($sformatf("d24_row%0d", i), bus24.BusA[63:0], (i == 23) ? 64'h2323 : 64'h0);
    end

    for (int v = 0; v < 10; v++) begin
      drive32(vecs[v].ra0, vecs[v].ra1, vecs[v].rw0, vecs[v].w0, vecs[v].we0,
              vecs[v].rw1, vecs[v].w1, vecs[v].we1);
      #1;
      check({vecs[v].name, "_a0"}, bus32.BusA[63:0], vecs[v].exp0);
      check({vecs[v].name, "_a1"}, bus32.BusA[127:64], vecs[v].exp1);
      step();
    end

    // Clear with a same-cycle write: write is bypassed now, then swept away.
    drive32(5'd6, 5'd5, 5'd6, 64'h66, 1'b1, 5'd0, 64'h0, 1'b0);
    bus32.Clear = 1'b1;
    #1;
    check("clear_cycle_byp", bus32.BusA[63:0], 64'h66);
    step();
    bus32.Clear = 1'b0;
    check("clear_ready_fall", 64'(bus32.Ready), 64'h0);
    drive32(5'd2, 5'd1, 5'd2, 64'h77, 1'b1, 5'd0, 64'h0, 1'b0);
    #1;
    check("sweep_read_a0", bus32.BusA[63:0], 64'h0);
    check("sweep_read_a1", bus32.BusA[127:64], 64'h0);
    count_ready(3, n32, n24);
    check("clear_sweep_len", 64'(n32), 64'd32);
    for (int i = 1; i <= 7; i++) begin
      drive32(5'(i), 5'd0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
      #1;
      check($sformatf("after_clear_r%0d", i), bus32.BusA[63:0], 64'h0);
    end

    // Reset at sweep row 10: the sweep must restart and take the full length.
    drive32(5'd20, 5'd0, 5'd20, 64'h2020, 1'b1, 5'd0, 64'h0, 1'b0);
    step();
    drive32(5'd20, 5'd0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0);
    #1;
    check("pre_reset_r20", bus32.BusA[63:0], 64'h2020);
    ResetN = 1'b0;
    @(negedge Clk) ResetN = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("mid_sweep_row", 64'(dut32.u_clear_seq.row_q), 64'd10);
    ResetN = 1'b0;
    #1;
    check("mid_sweep_reset_ready", 64'(bus32.Ready), 64'h0);
    check("mid_sweep_reset_row", 64'(dut32.u_clear_seq.row_q), 64'd0);
    @(negedge Clk) ResetN = 1'b1;
    count_ready(-1, n32, n24);
    check("restart_sweep_len", 64'(n32), 64'd32);
    #1;
    check("restart_r20", bus32.BusA[63:0], 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
